// File: rtl/memory_read_pkg.sv
// Shared types and constants for the memory-read pipeline stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//   memState   - stage FSM encoding
//   READ/WRITE, MEMORY, INSN/DATA - dCache request tag fields, TAG_WIDTH bits total
package memory_read_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ1,
        WAIT1,
        REQ2,
        WAIT2,
        HOLD,
        DRAIN
    } memState;

    localparam int TAG_WIDTH = 13;

    localparam logic       READ   = 1'b1;
    localparam logic       WRITE  = 1'b0;
    localparam logic [3:0] MEMORY = 4'b0001;
    localparam logic       INSN   = 1'b0;
    localparam logic       DATA   = 1'b1;

    // Tag layout: {direction, target, insn/data, 7 reserved bits}.
    function automatic logic [TAG_WIDTH-1:0] makeTag(input logic isWrite, input logic isInsn);
        return {isWrite ? WRITE : READ, MEMORY, isInsn ? INSN : DATA, 7'b0};
    endfunction

    // Src1 is always read first, so the entry state only depends on which
    // sources need the cache.
    function automatic memState firstState(input logic src1Mem, input logic src2Mem);
        if (src1Mem) begin
            return REQ1;
        end else if (src2Mem) begin
            return REQ2;
        end else begin
            return HOLD;
        end
    endfunction

endpackage

// File: rtl/memory_read_port.sv
// Single-read dCache handshake port: drives the request while the sequencer is in a request phase, acks responses in a wait phase.
// Latency: combinational; the sequencer decides how long each phase lasts.
// Backpressure: request held until reqack; response consumed in the same cycle respcyc is seen.
//   reqPhase/waitPhase in  - which half of the read the sequencer is in
//   addr               in  - byte address of the current read
//   reqcyc/req/reqtag  out - dCache request, address forced to 0 when idle
//   reqack             in  - request accepted; reflected on granted
//   respcyc/resp       in  - response valid/data
//   respack            out - response consumed; dataValid/data carry it to the sequencer
module mem_read_port
    import memory_read_pkg::*;
(
    input  logic                 reqPhase,
    input  logic                 waitPhase,
    input  logic [63:0]          addr,
    output logic                 reqcyc,
    output logic [63:0]          req,
    output logic [TAG_WIDTH-1:0] reqtag,
    input  logic                 reqack,
    output logic                 granted,
    input  logic                 respcyc,
    input  logic [63:0]          resp,
    output logic                 respack,
    output logic                 dataValid,
    output logic [63:0]          data
);

    assign reqcyc    = reqPhase;
    assign req       = reqPhase ? addr : 64'd0;
    assign reqtag    = makeTag(1'b0, 1'b0);
    assign granted   = reqPhase & reqack;
    // Only ack a response while a read is actually outstanding.
    assign respack   = waitPhase & respcyc;
    assign dataValid = respack;
    assign data      = resp;

endmodule

// File: rtl/memory_read.sv
// Memory-read pipeline stage: fetches memory source operands (Src1 then Src2) from the dCache and hands a full instruction to execute.
// Latency: 1 cycle with no memory sources; each read adds (cycles to reqack + cycles to respcyc + 1).
// Backpressure: stallOut high in every state except IDLE and HOLD with readyIn; HOLD keeps outputs stable until readyIn.
//   clk/reset                              - clock, synchronous active-high reset
//   validIn/killIn                         - upstream instruction valid / squash
//   opcodeIn, currentRipIn, isMemoryAccessSrc*In, memoryAddressSrc*In, operand*In - instruction fields
//   readyIn                                - execute accepts the output
//   reqcyc/req/reqtag/reqack, respcyc/resp/respack - dCache read channel
//   validOut, opcodeOut, currentRipOut, operand1Out, operand2Out - registered result
//   stallOut                               - combinational stall to upstream
module memory_read
    import memory_read_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 validIn,
    input  logic                 killIn,
    input  logic [7:0]           opcodeIn,
    input  logic [63:0]          currentRipIn,
    input  logic                 isMemoryAccessSrc1In,
    input  logic                 isMemoryAccessSrc2In,
    input  logic [63:0]          memoryAddressSrc1In,
    input  logic [63:0]          memoryAddressSrc2In,
    input  logic [63:0]          operand1In,
    input  logic [63:0]          operand2In,
    input  logic                 readyIn,
    output logic                 reqcyc,
    output logic [63:0]          req,
    output logic [TAG_WIDTH-1:0] reqtag,
    input  logic                 reqack,
    input  logic                 respcyc,
    input  logic [63:0]          resp,
    output logic                 respack,
    output logic                 validOut,
    output logic [7:0]           opcodeOut,
    output logic [63:0]          currentRipOut,
    output logic [63:0]          operand1Out,
    output logic [63:0]          operand2Out,
    output logic                 stallOut
);

    memState     state, nextState;
    logic        isMem2;
    logic [63:0] addr1, addr2;

    logic        accept;
    logic        capture1, capture2;
    logic        reqPhase, waitPhase;
    logic [63:0] portAddr;
    logic        granted, dataValid;
    logic [63:0] portData;

    mem_read_port port (
        .reqPhase  (reqPhase),
        .waitPhase (waitPhase),
        .addr      (portAddr),
        .reqcyc    (reqcyc),
        .req       (req),
        .reqtag    (reqtag),
        .reqack    (reqack),
        .granted   (granted),
        .respcyc   (respcyc),
        .resp      (resp),
        .respack   (respack),
        .dataValid (dataValid),
        .data      (portData)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        accept    = 1'b0;
        capture1  = 1'b0;
        capture2  = 1'b0;
        stallOut  = 1'b1;
        reqPhase  = 1'b0;
        waitPhase = 1'b0;
        portAddr  = addr1;
        case (state)
            IDLE: begin
                stallOut = 1'b0;
                if (validIn && !killIn) begin
                    accept    = 1'b1;
                    nextState = firstState(isMemoryAccessSrc1In, isMemoryAccessSrc2In);
                end
            end
            REQ1: begin
                reqPhase = 1'b1;
                // A kill that coincides with the grant still owes the cache a response ack.
                if (granted) begin
                    nextState = killIn ? DRAIN : WAIT1;
                end else if (killIn) begin
                    nextState = IDLE;
                end
            end
            WAIT1: begin
                waitPhase = 1'b1;
                // If the response lands in the kill cycle it is acked and dropped here,
                // otherwise DRAIN would wait for a response that already went by.
                if (killIn) begin
                    nextState = dataValid ? IDLE : DRAIN;
                end else if (dataValid) begin
                    capture1  = 1'b1;
                    nextState = isMem2 ? REQ2 : HOLD;
                end
            end
            REQ2: begin
                reqPhase = 1'b1;
                portAddr = addr2;
                if (granted) begin
                    nextState = killIn ? DRAIN : WAIT2;
                end else if (killIn) begin
                    nextState = IDLE;
                end
            end
            WAIT2: begin
                waitPhase = 1'b1;
                portAddr  = addr2;
                if (killIn) begin
                    nextState = dataValid ? IDLE : DRAIN;
                end else if (dataValid) begin
                    capture2  = 1'b1;
                    nextState = HOLD;
                end
            end
            HOLD: begin
                stallOut = !readyIn;
                if (killIn) begin
                    nextState = IDLE;
                end else if (readyIn) begin
                    if (validIn) begin
                        accept    = 1'b1;
                        nextState = firstState(isMemoryAccessSrc1In, isMemoryAccessSrc2In);
                    end else begin
                        nextState = IDLE;
                    end
                end
            end
            DRAIN: begin
                waitPhase = 1'b1;
                if (dataValid) begin
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Instruction latch. The output registers double as the operand latches:
    // register values are loaded on acceptance and overwritten by cache data.
    always_ff @(posedge clk) begin
        if (reset) begin
            validOut      <= 1'b0;
            opcodeOut     <= 8'd0;
            currentRipOut <= 64'd0;
            operand1Out   <= 64'd0;
            operand2Out   <= 64'd0;
            isMem2        <= 1'b0;
            addr1         <= 64'd0;
            addr2         <= 64'd0;
        end else begin
            validOut <= (nextState == HOLD);
            if (accept) begin
                opcodeOut     <= opcodeIn;
                currentRipOut <= currentRipIn;
                operand1Out   <= operand1In;
                operand2Out   <= operand2In;
                isMem2        <= isMemoryAccessSrc2In;
                addr1         <= memoryAddressSrc1In;
                addr2         <= memoryAddressSrc2In;
            end else if (capture1) begin
                operand1Out <= portData;
            end else if (capture2) begin
                operand2Out <= portData;
            end
        end
    end

endmodule

// File: tb/tb_memory_read.sv
module tb_memory_read;

    logic        clk = 1'b0;
    logic        reset, validIn, killIn, readyIn;
    logic [7:0]  opcodeIn;
    logic [63:0] currentRipIn, memoryAddressSrc1In, memoryAddressSrc2In, operand1In, operand2In;
    logic        isMemoryAccessSrc1In, isMemoryAccessSrc2In;
    logic        reqcyc, respack, validOut, stallOut;
    logic [63:0] req, operand1Out, operand2Out, currentRipOut;
    logic [12:0] reqtag;
    logic [7:0]  opcodeOut;
    logic        reqack = 1'b0, respcyc = 1'b0;
    logic [63:0] resp = 64'd0;

    always #5 clk = ~clk;

    memory_read dut (
        .clk(clk), .reset(reset), .validIn(validIn), .killIn(killIn),
        .opcodeIn(opcodeIn), .currentRipIn(currentRipIn),
        .isMemoryAccessSrc1In(isMemoryAccessSrc1In), .isMemoryAccessSrc2In(isMemoryAccessSrc2In),
        .memoryAddressSrc1In(memoryAddressSrc1In), .memoryAddressSrc2In(memoryAddressSrc2In),
        .operand1In(operand1In), .operand2In(operand2In), .readyIn(readyIn),
        .reqcyc(reqcyc), .req(req), .reqtag(reqtag), .reqack(reqack),
        .respcyc(respcyc), .resp(resp), .respack(respack),
        .validOut(validOut), .opcodeOut(opcodeOut), .currentRipOut(currentRipOut),
        .operand1Out(operand1Out), .operand2Out(operand2Out), .stallOut(stallOut)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // dCache model: acks a request after ackDelay extra cycles, answers
    // respDelay cycles after the ack, data looked up in memData.
    int          ackDelay = 0, respDelay = 0;
    int          phase = 0, cnt = 0, reqcycCycles = 0;
    logic [63:0] pendAddr = 64'd0;
    logic [63:0] memData [logic [63:0]];
    logic [63:0] reqLog [$];
    bit          overlapSeen = 0, tagBad = 0, ackBad = 0, sawReset;

    always begin
        @(posedge clk);
        sawReset = reset;
        #1;
        reqack  = 1'b0;
        respcyc = 1'b0;
        if (sawReset) begin
            phase = 0;
            cnt   = 0;
        end else begin
            if (reqcyc) begin
                reqcycCycles++;
                if (reqtag !== 13'h1180) tagBad = 1;
                if (phase != 0) overlapSeen = 1;
            end
            if (phase == 0) begin
                if (reqcyc) begin
                    if (cnt == ackDelay) begin
                        reqack   = 1'b1;
                        pendAddr = req;
                        reqLog.push_back(req);
                        phase = 1;
                        cnt   = 0;
                    end else cnt++;
                end else cnt = 0;
            end else begin
                if (cnt == respDelay) begin
                    respcyc = 1'b1;
                    resp    = memData.exists(pendAddr) ? memData[pendAddr] : 64'd0;
                    phase = 0;
                    cnt   = 0;
                end else cnt++;
            end
        end
        #1;
        if (respack && !respcyc) ackBad = 1;
    end

    typedef struct {
        logic        mem1, mem2;
        logic [63:0] addr1, addr2, op1, op2;
        logic [7:0]  opc;
        logic [63:0] rip;
        int          ackD, respD, expLat, expReqs, expReqCyc;
        logic [63:0] expOp1, expOp2;
    } vecT;

    vecT vecs [5];

    task automatic drive(input logic m1, input logic m2, input logic [63:0] a1, input logic [63:0] a2,
                         input logic [63:0] o1, input logic [63:0] o2, input logic [7:0] opc,
                         input logic [63:0] rip);
        validIn = 1'b1;
        isMemoryAccessSrc1In = m1; isMemoryAccessSrc2In = m2;
        memoryAddressSrc1In = a1;  memoryAddressSrc2In = a2;
        operand1In = o1; operand2In = o2; opcodeIn = opc; currentRipIn = rip;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  lat;
        bit  drained, sawValid;
        reset = 1'b1; validIn = 1'b0; killIn = 1'b0; readyIn = 1'b0;
        isMemoryAccessSrc1In = 1'b0; isMemoryAccessSrc2In = 1'b0;
        memoryAddressSrc1In = 64'd0; memoryAddressSrc2In = 64'd0;
        operand1In = 64'd0; operand2In = 64'd0; opcodeIn = 8'd0; currentRipIn = 64'd0;

        memData[64'h1000] = 64'hDEAD;
        memData[64'h2000] = 64'hAAAA_0000_0000_0001;
        memData[64'h2008] = 64'hBBBB_0000_0000_0002;
        memData[64'h3000] = 64'h3333_3333_3333_3333;
        memData[64'h4000] = 64'hFFFF_FFFF_FFFF_FFFF;
        memData[64'h5000] = 64'h5555;
        memData[64'h6000] = 64'h6666;

        //             m1 m2 addr1     addr2     op1    op2    opc    rip       ack rsp lat reqs rc  expOp1                 expOp2
        vecs[0] = '{1'b0, 1'b0, 64'h0,    64'h0,    64'd5,  64'd7,  8'h10, 64'h400000, 0, 0, 1, 0, 0, 64'd5,                 64'd7};
        vecs[1] = '{1'b1, 1'b0, 64'h1000, 64'h0,    64'h11, 64'h22, 8'h20, 64'h400004, 2, 2, 7, 1, 3, 64'hDEAD,              64'h22};
        vecs[2] = '{1'b0, 1'b1, 64'h0,    64'h3000, 64'h33, 64'h44, 8'h30, 64'h400008, 0, 0, 3, 1, 1, 64'h33,                64'h3333_3333_3333_3333};
        vecs[3] = '{1'b1, 1'b1, 64'h2000, 64'h2008, 64'h55, 64'h66, 8'h40, 64'h40000C, 1, 0, 7, 2, 4, 64'hAAAA_0000_0000_0001, 64'hBBBB_0000_0000_0002};
        vecs[4] = '{1'b1, 1'b1, 64'h4000, 64'h4000, 64'h77, 64'h88, 8'h50, 64'h400010, 0, 1, 7, 2, 2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
        check("rst.validOut", validOut, 0);
        check("rst.reqcyc", reqcyc, 0);
        check("rst.respack", respack, 0);
        check("rst.req", req, 0);
        check("rst.op1", operand1Out, 0);
        check("rst.op2", operand2Out, 0);
        check("rst.rip", currentRipOut, 0);
        check("rst.opcode", opcodeOut, 0);
        check("rst.stall", stallOut, 0);
        nextCycle();

        for (int i = 0; i < 5; i++) begin
            ackDelay = vecs[i].ackD;
            respDelay = vecs[i].respD;
            reqLog.delete();
            reqcycCycles = 0;
            readyIn = 1'b0;
            drive(vecs[i].mem1, vecs[i].mem2, vecs[i].addr1, vecs[i].addr2,
                  vecs[i].op1, vecs[i].op2, vecs[i].opc, vecs[i].rip);
            nextCycle();
            validIn = 1'b0;
            lat = 1;
            while (!validOut && lat < 40) begin
                nextCycle();
                lat++;
            end
            #2;
            check($sformatf("v%0d.latency", i), lat, vecs[i].expLat);
            check($sformatf("v%0d.op1", i), operand1Out, vecs[i].expOp1);
            check($sformatf("v%0d.op2", i), operand2Out, vecs[i].expOp2);
            check($sformatf("v%0d.opcode", i), opcodeOut, vecs[i].opc);
            check($sformatf("v%0d.rip", i), currentRipOut, vecs[i].rip);
            check($sformatf("v%0d.holdStall", i), stallOut, 1);
            readyIn = 1'b1;
            #1;
            check($sformatf("v%0d.readyStall", i), stallOut, 0);
            nextCycle();
            readyIn = 1'b0;
            #2;
            check($sformatf("v%0d.validCleared", i), validOut, 0);
            check($sformatf("v%0d.numReqs", i), reqLog.size(), vecs[i].expReqs);
            check($sformatf("v%0d.reqcycCycles", i), reqcycCycles, vecs[i].expReqCyc);
            if (vecs[i].expReqs == 2 && reqLog.size() == 2) begin
                check($sformatf("v%0d.firstAddr", i), reqLog[0], vecs[i].addr1);
                check($sformatf("v%0d.secondAddr", i), reqLog[1], vecs[i].addr2);
            end
            nextCycle();
        end

        // Kill during WAIT1: late response drained, next instruction waits for IDLE.
        ackDelay = 0; respDelay = 3;
        drive(1'b1, 1'b0, 64'h5000, 64'h0, 64'h1, 64'h2, 8'h60, 64'h500000);
        nextCycle();
        validIn = 1'b0;
        nextCycle();
        killIn = 1'b1;
        nextCycle();
        killIn = 1'b0;
        drive(1'b0, 1'b0, 64'h0, 64'h0, 64'd9, 64'd10, 8'h61, 64'h500004);
        drained = 0; sawValid = 0;
        for (int k = 0; k < 20 && !drained; k++) begin
            #2;
            if (validOut) sawValid = 1;
            if (respcyc) begin
                drained = 1;
                check("drain.respack", respack, 1);
                check("drain.stall", stallOut, 1);
            end else nextCycle();
        end
        check("drain.seen", drained, 1);
        check("drain.validOut", sawValid, 0);
        nextCycle();
        #2;
        check("postDrain.stall", stallOut, 0);
        check("postDrain.validOut", validOut, 0);
        nextCycle();
        validIn = 1'b0;
        #2;
        check("postDrain.newValid", validOut, 1);
        check("postDrain.op1", operand1Out, 9);
        check("postDrain.op2", operand2Out, 10);
        readyIn = 1'b1;
        nextCycle();
        readyIn = 1'b0;

        // HOLD with readyIn low for 4 cycles, then back-to-back acceptance.
        drive(1'b0, 1'b0, 64'h0, 64'h0, 64'h11, 64'h12, 8'h5A, 64'h600000);
        nextCycle();
        validIn = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #2;
            check($sformatf("hold%0d.valid", k), validOut, 1);
            check($sformatf("hold%0d.op1", k), operand1Out, 64'h11);
            check($sformatf("hold%0d.op2", k), operand2Out, 64'h12);
            check($sformatf("hold%0d.stall", k), stallOut, 1);
            nextCycle();
        end
        readyIn = 1'b1;
        drive(1'b0, 1'b0, 64'h0, 64'h0, 64'h21, 64'h22, 8'h5B, 64'h600004);
        #2;
        check("b2b.stall", stallOut, 0);
        nextCycle();
        validIn = 1'b0;
        #2;
        check("b2b.valid", validOut, 1);
        check("b2b.op1", operand1Out, 64'h21);
        check("b2b.opcode", opcodeOut, 8'h5B);
        nextCycle();
        readyIn = 1'b0;
        #2;
        check("b2b.cleared", validOut, 0);
        nextCycle();

        // Kill in IDLE blocks acceptance.
        drive(1'b1, 1'b0, 64'h1000, 64'h0, 64'h0, 64'h0, 8'h70, 64'h700000);
        killIn = 1'b1;
        nextCycle();
        validIn = 1'b0; killIn = 1'b0;
        #2;
        check("idleKill.reqcyc", reqcyc, 0);
        check("idleKill.stall", stallOut, 0);
        nextCycle();

        // Kill in REQ1 before the grant.
        ackDelay = 5;
        drive(1'b1, 1'b0, 64'h1000, 64'h0, 64'h0, 64'h0, 8'h71, 64'h700004);
        nextCycle();
        validIn = 1'b0;
        #2;
        check("reqKill.reqcycBefore", reqcyc, 1);
        killIn = 1'b1;
        nextCycle();
        killIn = 1'b0;
        #2;
        check("reqKill.reqcycAfter", reqcyc, 0);
        check("reqKill.stall", stallOut, 0);
        nextCycle();

        // Kill in the same cycle as reqack: must drain.
        ackDelay = 0; respDelay = 1;
        drive(1'b1, 1'b0, 64'h5000, 64'h0, 64'h0, 64'h0, 8'h72, 64'h700008);
        nextCycle();
        validIn = 1'b0;
        killIn = 1'b1;
        nextCycle();
        killIn = 1'b0;
        #2;
        check("ackKill.stall", stallOut, 1);
        check("ackKill.valid", validOut, 0);
        nextCycle();
        #2;
        check("ackKill.respack", respack, 1);
        nextCycle();
        #2;
        check("ackKill.idle", stallOut, 0);

        // Kill in HOLD.
        drive(1'b0, 1'b0, 64'h0, 64'h0, 64'h31, 64'h32, 8'h73, 64'h70000C);
        nextCycle();
        validIn = 1'b0;
        #2;
        check("holdKill.validBefore", validOut, 1);
        killIn = 1'b1;
        nextCycle();
        killIn = 1'b0;
        #2;
        check("holdKill.validAfter", validOut, 0);
        check("holdKill.stall", stallOut, 0);
        nextCycle();

        // Reset while in WAIT2.
        ackDelay = 0; respDelay = 5;
        drive(1'b0, 1'b1, 64'h0, 64'h6000, 64'h77, 64'h78, 8'h74, 64'h800000);
        nextCycle();
        validIn = 1'b0;
        nextCycle();
        #2;
        check("wait2.stall", stallOut, 1);
        reset = 1'b1;
        nextCycle();
        #2;
        check("midRst.validOut", validOut, 0);
        check("midRst.reqcyc", reqcyc, 0);
        check("midRst.respack", respack, 0);
        check("midRst.req", req, 0);
        check("midRst.op1", operand1Out, 0);
        check("midRst.op2", operand2Out, 0);
        check("midRst.rip", currentRipOut, 0);
        check("midRst.opcode", opcodeOut, 0);
        check("midRst.stall", stallOut, 0);
        reset = 1'b0;
        nextCycle();

        check("protocol.overlap", overlapSeen, 0);
        check("protocol.reqtag", tagBad, 0);
        check("protocol.respackWithoutRespcyc", ackBad, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/memory_read.md
MEMORY_READ -- requirements
Module: memory_read

Interface
REQ-001 Clock/reset: one clock, reset synchronous and active-high; all state changes on posedge clk.
REQ-002 clk  in  1  pipeline and dCache clock.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 validIn  in  1  upstream (register read) presents an instruction this cycle.
REQ-005 killIn  in  1  squash the instruction held or in flight.
REQ-006 opcodeIn / currentRipIn  in  8 / 64  passed through to the execute stage.
REQ-007 isMemoryAccessSrc1In, isMemoryAccessSrc2In  in  1 each  source operand comes from memory.
REQ-008 memoryAddressSrc1In, memoryAddressSrc2In  in  64 each  byte addresses of the memory sources.
REQ-009 operand1In, operand2In  in  64 each  register-file values, used when the source is not memory.
REQ-010 readyIn  in  1  execute stage accepts the output this cycle.
REQ-011 reqcyc / req / reqtag  out  1 / 64 / 13  dCache request; reqtag = {READ, MEMORY, DATA, 7'b0}.
REQ-012 reqack  in  1  dCache accepted the request.
REQ-013 respcyc / resp  in  1 / 64  dCache read data valid / data.
REQ-014 respack  out  1  response consumed; driven in the same cycle as respcyc.
REQ-015 validOut, opcodeOut, currentRipOut, operand1Out, operand2Out  out  1/8/64/64/64  registered result to execute.
REQ-016 stallOut  out  1  combinational; high when the stage cannot take a new instruction this cycle.

Function
REQ-017 FSM states: IDLE, REQ1, WAIT1, REQ2, WAIT2, HOLD, DRAIN.
REQ-018 IDLE, validIn=1, killIn=0: latch all inputs.
  - Src1 from memory -> REQ1.
  - Only Src2 from memory -> REQ2.
  - Neither from memory -> HOLD, with operands copied from operand1In/2In.
REQ-019 REQ1/REQ2: reqcyc=1 and req = latched address for the whole state; on reqack, drop reqcyc the next cycle and go to WAIT1/WAIT2.
REQ-020 WAIT1 on respcyc: capture resp into operand1, assert respack, then go to REQ2 if Src2 is from memory, else HOLD.
REQ-021 WAIT2 on respcyc: capture resp into operand2, assert respack, go to HOLD.
REQ-022 Read ordering: Src1 always reads before Src2; at most one read outstanding.
REQ-023 Identical addresses: if both sources are memory and the addresses are equal, Src2 is still read from the cache (no forwarding).
REQ-024 HOLD: validOut=1 and outputs stable; readyIn=1 clears validOut next cycle.
  - That next cycle the FSM goes to IDLE, or, if validIn=1 arrives in the same cycle as readyIn, it latches the new instruction directly (back-to-back, no bubble).
REQ-025 stallOut = 1 in every state except IDLE, and except HOLD with readyIn=1.
REQ-026 Latency: no memory sources -> validOut 1 cycle after acceptance; each memory read adds (reqack wait + response wait + 1) cycles.
REQ-027 killIn in REQ1/REQ2 before reqack: deassert reqcyc next cycle and go to IDLE.
REQ-028 killIn in REQ1/REQ2 in the same cycle as reqack: treat as a kill during WAIT (go to DRAIN).
REQ-029 killIn in WAIT1/WAIT2: go to DRAIN; DRAIN waits for respcyc, asserts respack, discards the data, then goes to IDLE.
REQ-030 killIn in HOLD: validOut=0 next cycle, go to IDLE.
REQ-031 killIn in IDLE blocks acceptance of validIn that cycle.
REQ-032 Kill priority: killIn has priority over readyIn and validIn.
REQ-033 reqcyc is never asserted outside REQ1/REQ2; respack is never asserted without respcyc.
REQ-034 Width handling: data is a full 64 bits, no extension or truncation; addresses are passed unmodified.

Reset
REQ-035 On reset: state=IDLE; validOut=0, reqcyc=0, respack=0.
  - req, operand1Out, operand2Out, currentRipOut = 0; opcodeOut = 0.
REQ-036 Reset mid-transaction: abandon any outstanding read without draining; the cache is reset in the same cycle.

Structure
REQ-037 Shared package: state enum, reqtag field constants (READ, WRITE, MEMORY, INSN, DATA), tag width 13.
REQ-038 One sub-module, mem_read_port: REQ/WAIT handshake for a single read.
  - Instantiated once and sequenced by the top FSM for Src1 then Src2.
REQ-039 Datapath latch registers stay in the top module.

Verification
REQ-040 No memory sources: operands 5 and 7 with readyIn=1 -> validOut=1 next cycle with 5/7, reqcyc never asserted.
REQ-041 Src1 memory at 0x1000: reqack at cycle 3 and resp 0xDEAD at cycle 6 -> operand1Out=0xDEAD, validOut in cycle 7, reqcyc low from cycle 4.
REQ-042 Both sources memory, 0x2000 then 0x2008 -> two sequential requests, never overlapped; operands match the returned data in order.
REQ-043 killIn during WAIT1 -> DRAIN acks the late response, validOut stays 0, next instruction is accepted the cycle after the drain.
REQ-044 readyIn=0 for 4 cycles in HOLD -> outputs constant and stallOut=1; then readyIn=1 with validIn=1 -> the new instruction is latched with no bubble.
REQ-045 reset asserted in WAIT2 -> next cycle all outputs are at their reset values and state=IDLE.
